opb_regbank_snap_simulink2ppc: RTL and testbench

//  Parametrised multi-channel successor to the single-register simulink2ppc OPB slave.
//  - Exposes C_NUM_CH user words to the PPC over OPB.
//  - Adds armed one-shot and continuous snapshot capture, so all channels read back atomically.
//  - Adds status and capture-count registers for software.
//  - Sits between Simulink user logic and the PLB2OPB bridge on ROACH.
//  - User logic runs on OPB_Clk (single domain).

---
 rtl/opb_regbank_snap_simulink2ppc_if.sv | 28 ++
 rtl/opb_regbank_snap_simulink2ppc.sv | 121 ++++++++++++
 tb/tb_opb_regbank_snap_simulink2ppc.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opb_regbank_snap_simulink2ppc_if.sv
// OPB slave-side bus bundle for opb_regbank_snap_simulink2ppc.
// OPB is big-endian: OPB bit k appears here as bit [W-1-k], so BE[3] is OPB_BE[0] and DBus[31] is OPB_DBus[0].
interface opb_regbank_snap_simulink2ppc_if #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32
);
    logic [C_OPB_AWIDTH-1:0]   OPB_ABus;
    logic [C_OPB_DWIDTH/8-1:0] OPB_BE;
    logic [C_OPB_DWIDTH-1:0]   OPB_DBus;
    logic                      OPB_RNW;
    logic                      OPB_select;
    logic                      OPB_seqAddr;
    logic [C_OPB_DWIDTH-1:0]   Sl_DBus;
    logic                      Sl_xferAck;
    logic                      Sl_errAck;
    logic                      Sl_retry;
    logic                      Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_regbank_snap_simulink2ppc.sv
// Multi-channel OPB register bank with armed one-shot / continuous atomic snapshot capture.
// Optional capture timestamp: define OPB_REGBANK_TSTAMP_EN to add the free-running counter and TSTAMP register.
module opb_regbank_snap_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0800,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_08FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_CH_WIDTH   = 32
) (
    input  logic                           OPB_Clk,
    input  logic                           OPB_Rst_n,
    opb_regbank_snap_simulink2ppc_if.slave opb,
    input  logic [C_NUM_CH*C_CH_WIDTH-1:0] user_data_in,
    input  logic                           user_valid,
    output logic                           snap_done
);
    localparam int WORD_W = C_OPB_AWIDTH - 2;
    localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(0);
    localparam logic [WORD_W-1:0] W_STAT   = WORD_W'(1);
    localparam logic [WORD_W-1:0] W_TSTAMP = WORD_W'(2);
    localparam logic [WORD_W-1:0] W_CH0    = WORD_W'(4);

    logic [C_OPB_AWIDTH-1:0] offset;
    logic [WORD_W-1:0]       word;
    logic                    in_range, hit, rd_hit, wr_hit, ctrl_wr;
    logic [C_OPB_DWIDTH-1:0] rd_data;

    logic                  armed, cont_mode, snap_valid, capture;
    logic [15:0]           count;
    logic [C_CH_WIDTH-1:0] ch [C_NUM_CH];

    assign offset   = opb.OPB_ABus - C_BASEADDR;
    assign word     = offset[C_OPB_AWIDTH-1:2];
    assign in_range = (opb.OPB_ABus >= C_BASEADDR) && (opb.OPB_ABus <= C_HIGHADDR);
    assign hit      = opb.OPB_select && in_range && !opb.Sl_xferAck;
    assign rd_hit   = hit && opb.OPB_RNW;
    assign wr_hit   = hit && !opb.OPB_RNW;
    assign ctrl_wr  = wr_hit && (word == W_CTRL) && opb.OPB_BE[0];
    assign capture  = user_valid && (armed || cont_mode);

    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

`ifdef OPB_REGBANK_TSTAMP_EN
    logic [31:0] cycle_cnt, tstamp;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cycle_cnt <= '0;
            tstamp    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (capture) tstamp <= cycle_cnt;
        end
    end
`endif

    always_comb begin
        // NOTE: default every output first so no path through the mux can infer a latch.
        rd_data = '0;
        if (word == W_CTRL) begin
            rd_data = {30'b0, cont_mode, armed};
        end else if (word == W_STAT) begin
            rd_data = {count, 14'b0, snap_valid, armed};
        end else if (word == W_TSTAMP) begin
`ifdef OPB_REGBANK_TSTAMP_EN
            rd_data = tstamp;
`endif
        end else begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (word == W_CH0 + WORD_W'(i)) rd_data[C_CH_WIDTH-1:0] = ch[i];
            end
        end
    end

    // Data is registered alongside the ack, so a capture on the same edge is not yet visible.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!OPB_Rst_n) begin
            opb.Sl_xferAck <= 1'b0;
            opb.Sl_DBus    <= '0;
        end else begin
            opb.Sl_xferAck <= hit;
            opb.Sl_DBus    <= rd_hit ? rd_data : '0;
        end
    end

    // An arm write issued alongside a capture takes priority for armed/snap_valid.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            armed      <= 1'b0;
            cont_mode  <= 1'b0;
            snap_valid <= 1'b0;
            snap_done  <= 1'b0;
            count      <= '0;
            // NOTE: this is a small flop array, not RAM, so it is cleared to keep stale data from software.
            for (int i = 0; i < C_NUM_CH; i++) ch[i] <= '0;
        end else begin
            snap_done <= capture;
            if (capture) begin
                for (int i = 0; i < C_NUM_CH; i++) ch[i] <= user_data_in[i*C_CH_WIDTH +: C_CH_WIDTH];
                count      <= count + 16'd1;
                snap_valid <= 1'b1;
                if (!cont_mode) armed <= 1'b0;
            end
            if (ctrl_wr) begin
                cont_mode <= opb.OPB_DBus[1];
                if (opb.OPB_DBus[0]) begin
                    armed      <= 1'b1;
                    snap_valid <= 1'b0;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, opb.OPB_seqAddr, offset[1:0],
                           opb.OPB_BE[C_OPB_DWIDTH/8-1:1], opb.OPB_DBus[C_OPB_DWIDTH-1:2]};
endmodule

// File: tb/tb_opb_regbank_snap_simulink2ppc.sv
// Self-checking bench for opb_regbank_snap_simulink2ppc: directed vector table, corner sequences, random vs model.
// Honours OPB_REGBANK_TSTAMP_EN the same way as the design.
module tb_opb_regbank_snap_simulink2ppc;
    localparam logic [31:0] BASE = 32'h0100_0800;
    localparam logic [31:0] HIGH = 32'h0100_08FF;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH*32-1:0] user_data_in = '0;
    logic user_valid = 1'b0;
    logic snap_done;

    opb_regbank_snap_simulink2ppc_if bus ();

    opb_regbank_snap_simulink2ppc dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .opb         (bus),
        .user_data_in(user_data_in),
        .user_valid  (user_valid),
        .snap_done   (snap_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int idle_bad = 0;
    int cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && !bus.Sl_xferAck && bus.Sl_DBus !== 32'h0) idle_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: register contents as software sees them.
    bit          m_armed, m_cont, m_valid;
    int          m_count;
    logic [31:0] m_ch [NCH];
    logic [31:0] m_tstamp;

    function automatic void m_reset();
        m_armed = 0; m_cont = 0; m_valid = 0; m_count = 0; m_tstamp = 0;
        foreach (m_ch[i]) m_ch[i] = 0;
    endfunction

    function automatic bit m_in_range(input logic [31:0] addr);
        return addr >= BASE && addr <= HIGH;
    endfunction

    function automatic bit m_cycle(input bit uv, input logic [NCH*32-1:0] d, input bit wr,
                                   input logic [31:0] addr, input logic [3:0] be,
                                   input logic [31:0] wdata, input int now);
        bit cap;
        cap = uv && (m_armed || m_cont);
        if (cap) begin
            for (int i = 0; i < NCH; i++) m_ch[i] = d[i*32 +: 32];
            m_count = (m_count + 1) % 65536;
            m_valid = 1;
            m_tstamp = now;
            if (!m_cont) m_armed = 0;
        end
        if (wr && m_in_range(addr) && addr - BASE == 0 && be[0]) begin
            m_cont = wdata[1];
            if (wdata[0]) begin
                m_armed = 1;
                m_valid = 0;
            end
        end
        return cap;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        int off;
        off = int'(addr - BASE);
        if (off == 0) return {30'b0, m_cont, m_armed};
        if (off == 4) return {m_count[15:0], 14'b0, m_valid, m_armed};
`ifdef OPB_REGBANK_TSTAMP_EN
        if (off == 8) return m_tstamp;
`endif
        if (off >= 16 && off < 16 + 4 * NCH && off % 4 == 0) return m_ch[(off - 16) / 4];
        return 32'h0;
    endfunction

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic opb_xfer(input bit rnw, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input bit uv, input logic [NCH*32-1:0] uvd,
                            output logic [31:0] rdata, output bit acked, output bit done);
        bus.OPB_ABus = addr; bus.OPB_RNW = rnw; bus.OPB_BE = be; bus.OPB_DBus = wdata;
        bus.OPB_select = 1'b1;
        if (uv) begin
            user_valid = 1'b1;
            user_data_in = uvd;
        end
        acked = 0; done = 0; rdata = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            user_valid = 1'b0;
            @(negedge clk);
            if (k == 0) done = snap_done;
            if (bus.Sl_xferAck) begin
                acked = 1;
                rdata = bus.Sl_DBus;
                break;
            end
        end
        @(posedge clk); #1;
        bus.OPB_select = 1'b0;
        bus.OPB_DBus = '0;
    endtask

    task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bit a, dn;
        opb_xfer(1'b1, addr, 4'hF, 32'h0, 1'b0, '0, d, a, dn);
        check({name, "_ack"}, {31'b0, a}, 32'd1);
        check(name, d, exp);
    endtask

    task automatic do_write(input string name, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, input bit uv, input logic [NCH*32-1:0] uvd);
        logic [31:0] d;
        bit a, dn, cap;
        cap = m_cycle(uv, uvd, 1'b1, addr, be, data, cyc);
        opb_xfer(1'b0, addr, be, data, uv, uvd, d, a, dn);
        check({name, "_ack"}, {31'b0, a}, 32'd1);
        if (uv) check({name, "_snap_done"}, {31'b0, dn}, {31'b0, cap});
    endtask

    task automatic pulse_valid(input logic [NCH*32-1:0] d, output bit done, output bit cap);
        cap = m_cycle(1'b1, d, 1'b0, 32'h0, 4'h0, 32'h0, cyc);
        user_data_in = d;
        user_valid = 1'b1;
        @(posedge clk); #1;
        user_valid = 1'b0;
        @(negedge clk);
        done = snap_done;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b1; bus.OPB_ABus = '0;
        bus.OPB_BE = '0; bus.OPB_DBus = '0; bus.OPB_seqAddr = 1'b0;
        user_valid = 1'b0; user_data_in = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef enum {V_RD, V_WR, V_UV} vkind_e;
    typedef struct {
        vkind_e      kind;
        string       name;
        logic [31:0] off;
        logic [3:0]  be;
        logic [31:0] data;
        int          ch;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input vkind_e k, input string n, input logic [31:0] off,
                                input logic [3:0] be, input logic [31:0] data, input int ch,
                                input logic [31:0] exp);
        vec_t v;
        v.kind = k; v.name = n; v.off = off; v.be = be; v.data = data; v.ch = ch; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [NCH*32-1:0] uvd;
        bit a, dn, cap;
        int acks, bad;

        // For V_UV, exp is the expected snap_done; for V_WR, the write is only checked for its ack.
        add(V_RD, "rst_stat",     32'h04, 4'hF, 0, 0, 32'h0);
        add(V_RD, "rst_ctrl",     32'h00, 4'hF, 0, 0, 32'h0);
        add(V_RD, "rst_ch0",      32'h10, 4'hF, 0, 0, 32'h0);
        add(V_RD, "rst_tstamp",   32'h08, 4'hF, 0, 0, 32'h0);
        add(V_RD, "unmapped_0c",  32'h0C, 4'hF, 0, 0, 32'h0);
        add(V_WR, "arm",          32'h00, 4'hF, 32'h1, 0, 0);
        add(V_UV, "cap1",         0, 0, 32'hDEADBEEF, 1, 32'h1);
        add(V_RD, "stat_cap1",    32'h04, 4'hF, 0, 0, 32'h0001_0002);
        add(V_RD, "ch1_cap1",     32'h14, 4'hF, 0, 0, 32'hDEADBEEF);
        add(V_RD, "ctrl_disarm",  32'h00, 4'hF, 0, 0, 32'h0);
        add(V_UV, "unarmed",      0, 0, 32'h1234_5678, 1, 32'h0);
        add(V_RD, "ch1_held",     32'h14, 4'hF, 0, 0, 32'hDEADBEEF);
        add(V_RD, "stat_held",    32'h04, 4'hF, 0, 0, 32'h0001_0002);
        add(V_WR, "cont_on",      32'h00, 4'hF, 32'h2, 0, 0);
        add(V_UV, "cont1",        0, 0, 32'h11, 0, 32'h1);
        add(V_UV, "cont2",        0, 0, 32'h22, 0, 32'h1);
        add(V_UV, "cont3",        0, 0, 32'h33, 0, 32'h1);
        add(V_RD, "ch0_cont",     32'h10, 4'hF, 0, 0, 32'h33);
        add(V_RD, "stat_cont",    32'h04, 4'hF, 0, 0, 32'h0004_0002);
        add(V_RD, "ctrl_cont",    32'h00, 4'hF, 0, 0, 32'h2);
        add(V_WR, "cont_off",     32'h00, 4'hF, 32'h0, 0, 0);
        add(V_WR, "stat_ro_wr",   32'h04, 4'hF, 32'hFFFF_FFFF, 0, 0);
        add(V_RD, "stat_ro",      32'h04, 4'hF, 0, 0, 32'h0004_0002);
        add(V_WR, "ctrl_no_be",   32'h00, 4'h0, 32'h3, 0, 0);
        add(V_RD, "ctrl_no_be",   32'h00, 4'hF, 0, 0, 32'h0);
        add(V_WR, "arm_be3",      32'h00, 4'h1, 32'h1, 0, 0);
        add(V_RD, "stat_rearm",   32'h04, 4'hF, 0, 0, 32'h0004_0001);
        add(V_RD, "ch4_unimpl",   32'h20, 4'hF, 0, 0, 32'h0);
        add(V_RD, "unmapped_fc",  32'hFC, 4'hF, 0, 0, 32'h0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                V_RD: do_read(vecs[i].name, BASE + vecs[i].off, vecs[i].exp);
                V_WR: do_write(vecs[i].name, BASE + vecs[i].off, vecs[i].be, vecs[i].data, 1'b0, '0);
                default: begin
                    uvd = '0;
                    uvd[vecs[i].ch*32 +: 32] = vecs[i].data;
                    pulse_valid(uvd, dn, cap);
                    check({vecs[i].name, "_snap_done"}, {31'b0, dn}, vecs[i].exp);
                end
            endcase
        end

        // Arm write coincident with user_valid: no capture that edge, next pulse captures.
        pulse_valid({4{32'hAAAA_0000}}, dn, cap);
        check("consume_arm_done", {31'b0, dn}, 32'd1);
        do_write("arm_with_uv", BASE, 4'hF, 32'h1, 1'b1, {4{32'h5555_5555}});
        do_read("stat_arm_uv", BASE + 32'h04, 32'h0005_0001);
        do_read("ch2_arm_uv", BASE + 32'h18, 32'hAAAA_0000);
        pulse_valid({4{32'h0BAD_F00D}}, dn, cap);
        check("post_arm_done", {31'b0, dn}, 32'd1);
        do_read("stat_post_arm", BASE + 32'h04, 32'h0006_0002);
        do_read("ch3_post_arm", BASE + 32'h1C, 32'h0BAD_F00D);

        // Select held high: an ack every second cycle, bus zero in between.
        bus.OPB_ABus = BASE + 32'h04; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
        acks = 0; bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.Sl_xferAck) begin
                acks++;
                if (bus.Sl_DBus !== 32'h0006_0002) bad++;
            end
        end
        @(posedge clk); #1;
        bus.OPB_select = 1'b0;
        check("b2b_acks", acks, 3);
        check("b2b_data", bad, 0);

        // Outside the decode window nobody answers.
        opb_xfer(1'b1, HIGH + 32'h1, 4'hF, 0, 1'b0, '0, d, a, dn);
        check("above_high_noack", {31'b0, a}, 32'd0);
        opb_xfer(1'b1, BASE - 32'h4, 4'hF, 0, 1'b0, '0, d, a, dn);
        check("below_base_noack", {31'b0, a}, 32'd0);

        // Reset while a read is pending aborts the ack and clears state.
        bus.OPB_ABus = BASE + 32'h14; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midreset_ack", {31'b0, bus.Sl_xferAck}, 32'd0);
        check("midreset_dbus", bus.Sl_DBus, 32'h0);
        check("midreset_done", {31'b0, snap_done}, 32'd0);
        do_reset();
        do_read("after_reset_stat", BASE + 32'h04, 32'h0);
        do_read("after_reset_ch3", BASE + 32'h1C, 32'h0);

`ifdef OPB_REGBANK_TSTAMP_EN
        do_write("ts_arm", BASE, 4'hF, 32'h1, 1'b0, '0);
        while (cyc < 100) begin
            @(posedge clk); #1;
        end
        pulse_valid({4{32'h7}}, dn, cap);
        do_read("tstamp_100", BASE + 32'h08, 32'd100);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int op;
            logic [31:0] addr;
            logic [3:0]  be;
            op = $urandom_range(0, 9);
            uvd = {$urandom, $urandom, $urandom, $urandom};
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            if (op <= 2) begin
                do_write("rnd_ctrl", BASE, be, 32'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, uvd);
            end else if (op == 3) begin
                do_write("rnd_wr", BASE + 32'($urandom_range(0, 63) * 4), be, $urandom,
                         $urandom_range(0, 3) == 0, uvd);
            end else if (op <= 6) begin
                pulse_valid(uvd, dn, cap);
                check("rnd_snap_done", {31'b0, dn}, {31'b0, cap});
            end else begin
                int k;
                k = $urandom_range(0, 11);
                case (k)
                    0, 1, 2, 3: addr = BASE + 32'(k * 4);
                    10:         addr = BASE + 32'hFC;
                    11:         addr = BASE + 32'h80;
                    default:    addr = BASE + 32'h10 + 32'((k - 4) * 4);
                endcase
                do_read("rnd_rd", addr, m_read(addr));
            end
        end

        check("dbus_idle_zero", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
